// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : Registered RV32I decode/issue stage feeding the ALU operand and
//             operation inputs, with valid/ready handshakes, flush and an
//             issued-bundle counter.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            instr_valid_i,
   output logic            instr_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic [4:0]      rs1_addr_o,
   output logic [4:0]      rs2_addr_o,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic            flush_i,
   output logic            ex_valid_o,
   input  logic            ex_ready_i,
   output logic [XLEN-1:0] operand_a_o,
   output logic [XLEN-1:0] operand_b_o,
   output logic [3:0]      alu_op_o,
   output logic [4:0]      rd_addr_o,
   output logic            rd_we_o,
   output logic            illegal_o,
   output logic [31:0]     issued_count_o
);

   // ALU operation encoding
   localparam logic [3:0] c_op_add  = 4'd0;
   localparam logic [3:0] c_op_sub  = 4'd1;
   localparam logic [3:0] c_op_and  = 4'd2;
   localparam logic [3:0] c_op_or   = 4'd3;
   localparam logic [3:0] c_op_xor  = 4'd4;
   localparam logic [3:0] c_op_slt  = 4'd5;
   localparam logic [3:0] c_op_sltu = 4'd6;
   localparam logic [3:0] c_op_sll  = 4'd7;
   localparam logic [3:0] c_op_srl  = 4'd8;
   localparam logic [3:0] c_op_sra  = 4'd9;
   localparam logic [3:0] c_op_lui  = 4'd10;

   localparam logic [6:0] c_opc_op_imm = 7'b0010011;
   localparam logic [6:0] c_opc_op     = 7'b0110011;
   localparam logic [6:0] c_opc_lui    = 7'b0110111;
   localparam logic [6:0] c_opc_auipc  = 7'b0010111;
   localparam logic [6:0] c_opc_jal    = 7'b1101111;
   localparam logic [6:0] c_opc_jalr   = 7'b1100111;

   localparam logic [6:0] c_f7_base = 7'b0000000;
   localparam logic [6:0] c_f7_alt  = 7'b0100000;

   // Instruction fields
   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic [4:0] w_rd;
   assign w_opcode = instr_i[6:0];
   assign w_funct3 = instr_i[14:12];
   assign w_funct7 = instr_i[31:25];
   assign w_rd     = instr_i[11:7];

   assign rs1_addr_o = instr_i[19:15];
   assign rs2_addr_o = instr_i[24:20];

   // Registered state
   logic            ex_valid_q,  ex_valid_d;
   logic [XLEN-1:0] operand_a_q, operand_a_d;
   logic [XLEN-1:0] operand_b_q, operand_b_d;
   logic [3:0]      alu_op_q,    alu_op_d;
   logic [4:0]      rd_addr_q,   rd_addr_d;
   logic            rd_we_q,     rd_we_d;
   logic            illegal_q,   illegal_d;
   logic [31:0]     issued_count_q, issued_count_d;

   // Decoded bundle for the instruction currently presented
   logic [XLEN-1:0] w_dec_a;
   logic [XLEN-1:0] w_dec_b;
   logic [3:0]      w_dec_op;
   logic            w_dec_illegal;
   logic            w_load;

   assign instr_ready_o = !ex_valid_q || ex_ready_i;
   assign w_load        = instr_valid_i && instr_ready_o;

   // Decode opcode/funct fields into ALU operands and operation
   always_comb begin
      w_dec_a       = rs1_data_i;
      w_dec_b       = '0;
      w_dec_op      = c_op_add;
      w_dec_illegal = 1'b0;
      unique case (w_opcode)
         c_opc_op_imm: begin
            w_dec_b = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
            unique case (w_funct3)
               3'b000: w_dec_op = c_op_add;
               3'b010: w_dec_op = c_op_slt;
               3'b011: w_dec_op = c_op_sltu;
               3'b100: w_dec_op = c_op_xor;
               3'b110: w_dec_op = c_op_or;
               3'b111: w_dec_op = c_op_and;
               3'b001: begin
                  w_dec_b       = {{(XLEN-5){1'b0}}, instr_i[24:20]};
                  w_dec_op      = c_op_sll;
                  w_dec_illegal = (w_funct7 != c_f7_base);
               end
               default: begin // 3'b101: logical or arithmetic right shift
                  w_dec_b  = {{(XLEN-5){1'b0}}, instr_i[24:20]};
                  w_dec_op = (w_funct7 == c_f7_alt) ? c_op_sra : c_op_srl;
                  w_dec_illegal = (w_funct7 != c_f7_base) && (w_funct7 != c_f7_alt);
               end
            endcase
         end
         c_opc_op: begin
            w_dec_b = rs2_data_i;
            if (w_funct7 == c_f7_base) begin
               unique case (w_funct3)
                  3'b000:  w_dec_op = c_op_add;
                  3'b001:  w_dec_op = c_op_sll;
                  3'b010:  w_dec_op = c_op_slt;
                  3'b011:  w_dec_op = c_op_sltu;
                  3'b100:  w_dec_op = c_op_xor;
                  3'b101:  w_dec_op = c_op_srl;
                  3'b110:  w_dec_op = c_op_or;
                  default: w_dec_op = c_op_and;
               endcase
            end else if (w_funct7 == c_f7_alt && w_funct3 == 3'b000) begin
               w_dec_op = c_op_sub;
            end else if (w_funct7 == c_f7_alt && w_funct3 == 3'b101) begin
               w_dec_op = c_op_sra;
            end else begin
               w_dec_illegal = 1'b1;
            end
         end
         c_opc_lui: begin
            w_dec_a  = '0;
            w_dec_b  = {instr_i[31:12], 12'b0};
            w_dec_op = c_op_lui;
         end
         c_opc_auipc: begin
            w_dec_a = pc_i;
            w_dec_b = {instr_i[31:12], 12'b0};
         end
         c_opc_jal: begin
            // Link value pc+4 is computed by the ALU
            w_dec_a = pc_i;
            w_dec_b = XLEN'(4);
         end
         c_opc_jalr: begin
            w_dec_a       = pc_i;
            w_dec_b       = XLEN'(4);
            w_dec_illegal = (w_funct3 != 3'b000);
         end
         default: w_dec_illegal = 1'b1;
      endcase
      // Illegal bundles carry zeroed operands so execute sees a benign ADD
      if (w_dec_illegal) begin
         w_dec_a  = '0;
         w_dec_b  = '0;
         w_dec_op = c_op_add;
      end
   end

   // Next-state: flush beats load, load beats drain, otherwise hold
   always_comb begin
      ex_valid_d  = ex_valid_q;
      operand_a_d = operand_a_q;
      operand_b_d = operand_b_q;
      alu_op_d    = alu_op_q;
      rd_addr_d   = rd_addr_q;
      rd_we_d     = rd_we_q;
      illegal_d   = illegal_q;
      if (flush_i) begin
         ex_valid_d = 1'b0;
      end else if (w_load) begin
         ex_valid_d  = 1'b1;
         operand_a_d = w_dec_a;
         operand_b_d = w_dec_b;
         alu_op_d    = w_dec_op;
         rd_addr_d   = w_rd;
         rd_we_d     = !w_dec_illegal && (w_rd != 5'd0);
         illegal_d   = w_dec_illegal;
      end else if (ex_valid_q && ex_ready_i) begin
         ex_valid_d = 1'b0;
      end
   end

   // Count bundles accepted by execute; flushed cycles do not count
   always_comb begin
      issued_count_d = issued_count_q;
      if (ex_valid_q && ex_ready_i && !flush_i) begin
         issued_count_d = issued_count_q + 32'd1;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_valid_q     <= 1'b0;
         operand_a_q    <= '0;
         operand_b_q    <= '0;
         alu_op_q       <= c_op_add;
         rd_addr_q      <= '0;
         rd_we_q        <= 1'b0;
         illegal_q      <= 1'b0;
         issued_count_q <= '0;
      end else begin
         ex_valid_q     <= ex_valid_d;
         operand_a_q    <= operand_a_d;
         operand_b_q    <= operand_b_d;
         alu_op_q       <= alu_op_d;
         rd_addr_q      <= rd_addr_d;
         rd_we_q        <= rd_we_d;
         illegal_q      <= illegal_d;
         issued_count_q <= issued_count_d;
      end
   end

   assign ex_valid_o     = ex_valid_q;
   assign operand_a_o    = operand_a_q;
   assign operand_b_o    = operand_b_q;
   assign alu_op_o       = alu_op_q;
   assign rd_addr_o      = rd_addr_q;
   assign rd_we_o        = rd_we_q;
   assign illegal_o      = illegal_q;
   assign issued_count_o = issued_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Directed self-checking bench for alu_issue_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  alu_op;
   logic [4:0]  rd_addr;
   logic        rd_we;
   logic        illegal;
   logic [31:0] issued_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.XLEN(32)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .instr_valid_i  (instr_valid),
      .instr_ready_o  (instr_ready),
      .instr_i        (instr),
      .pc_i           (pc),
      .rs1_addr_o     (rs1_addr),
      .rs2_addr_o     (rs2_addr),
      .rs1_data_i     (rs1_data),
      .rs2_data_i     (rs2_data),
      .flush_i        (flush),
      .ex_valid_o     (ex_valid),
      .ex_ready_i     (ex_ready),
      .operand_a_o    (op_a),
      .operand_b_o    (op_b),
      .alu_op_o       (alu_op),
      .rd_addr_o      (rd_addr),
      .rd_we_o        (rd_we),
      .illegal_o      (illegal),
      .issued_count_o (issued_count)
   );

   // Drive one instruction at the falling edge
   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic rdy, input logic fl);
      @(negedge clk);
      instr_valid = v;
      instr       = ins;
      pc          = p;
      rs1_data    = d1;
      rs2_data    = d2;
      ex_ready    = rdy;
      flush       = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      step();
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", ex_valid); end
      total++; if (alu_op !== 4'd0) begin bad++; $display("FAIL reset_op got=%0h exp=0", alu_op); end
      total++; if (op_a !== 32'h0 || op_b !== 32'h0) begin bad++; $display("FAIL reset_operands got=%h/%h exp=0/0", op_a, op_b); end
      total++; if (rd_we !== 1'b0 || illegal !== 1'b0 || rd_addr !== 5'd0) begin bad++; $display("FAIL reset_flags got we=%0b ill=%0b rd=%0d exp=0/0/0", rd_we, illegal, rd_addr); end
      total++; if (issued_count !== 32'h0) begin bad++; $display("FAIL reset_count got=%0h exp=0", issued_count); end
      total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", instr_ready); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ADDI then SUB on consecutive cycles with execute always ready
   task automatic test_back_to_back();
      drive(1'b1, 32'hFFF00093, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      total++; if (rs1_addr !== 5'd0 || rs2_addr !== 5'd31) begin bad++; $display("FAIL addi_rs_addr got=%0d/%0d exp=0/31", rs1_addr, rs2_addr); end
      step();
      total++; if (ex_valid !== 1'b1 || op_a !== 32'h0 || op_b !== 32'hFFFFFFFF || alu_op !== 4'd0)
         begin bad++; $display("FAIL addi_bundle got v=%0b a=%h b=%h op=%0d exp 1/0/ffffffff/0", ex_valid, op_a, op_b, alu_op); end
      total++; if (rd_addr !== 5'd1 || rd_we !== 1'b1 || illegal !== 1'b0)
         begin bad++; $display("FAIL addi_rd got rd=%0d we=%0b ill=%0b exp 1/1/0", rd_addr, rd_we, illegal); end
      total++; if (issued_count !== 32'd0) begin bad++; $display("FAIL addi_count got=%0d exp=0", issued_count); end
      drive(1'b1, 32'h402081B3, 32'h0, 32'h10, 32'h3, 1'b1, 1'b0);
      step();
      total++; if (op_a !== 32'h10 || op_b !== 32'h3 || alu_op !== 4'd1 || rd_addr !== 5'd3 || rd_we !== 1'b1)
         begin bad++; $display("FAIL sub_bundle got a=%h b=%h op=%0d rd=%0d we=%0b exp 10/3/1/3/1", op_a, op_b, alu_op, rd_addr, rd_we); end
      total++; if (issued_count !== 32'd1) begin bad++; $display("FAIL b2b_count got=%0d exp=1", issued_count); end
   endtask

   task automatic test_lui_jal();
      drive(1'b1, 32'h123452B7, 32'h0, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
      step();
      total++; if (op_a !== 32'h0 || op_b !== 32'h12345000 || alu_op !== 4'd10 || rd_addr !== 5'd5)
         begin bad++; $display("FAIL lui_bundle got a=%h b=%h op=%0d rd=%0d exp 0/12345000/10/5", op_a, op_b, alu_op, rd_addr); end
      drive(1'b1, 32'h008000EF, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      total++; if (op_a !== 32'h100 || op_b !== 32'h4 || alu_op !== 4'd0 || rd_we !== 1'b1 || rd_addr !== 5'd1)
         begin bad++; $display("FAIL jal_bundle got a=%h b=%h op=%0d we=%0b rd=%0d exp 100/4/0/1/1", op_a, op_b, alu_op, rd_we, rd_addr); end
      // AUIPC x2,0x1 at pc 0x40 -> A=0x40, B=0x1000, ADD
      drive(1'b1, 32'h00001117, 32'h40, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      total++; if (op_a !== 32'h40 || op_b !== 32'h1000 || alu_op !== 4'd0 || rd_addr !== 5'd2)
         begin bad++; $display("FAIL auipc_bundle got a=%h b=%h op=%0d rd=%0d exp 40/1000/0/2", op_a, op_b, alu_op, rd_addr); end
   endtask

   task automatic test_illegal();
      drive(1'b1, 32'h40109093, 32'h0, 32'h55, 32'h0, 1'b1, 1'b0);
      step();
      total++; if (illegal !== 1'b1 || rd_we !== 1'b0 || ex_valid !== 1'b1 || op_a !== 32'h0 || op_b !== 32'h0 || alu_op !== 4'd0)
         begin bad++; $display("FAIL slli_f7 got ill=%0b we=%0b v=%0b a=%h b=%h op=%0d exp 1/0/1/0/0/0", illegal, rd_we, ex_valid, op_a, op_b, alu_op); end
      drive(1'b1, 32'h00000063, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      total++; if (illegal !== 1'b1 || rd_we !== 1'b0 || ex_valid !== 1'b1)
         begin bad++; $display("FAIL branch_illegal got ill=%0b we=%0b v=%0b exp 1/0/1", illegal, rd_we, ex_valid); end
      // SRAI x1,x1,1 is legal with funct7=0100000
      drive(1'b1, 32'h4010D093, 32'h0, 32'h80000000, 32'h0, 1'b1, 1'b0);
      step();
      total++; if (illegal !== 1'b0 || op_a !== 32'h80000000 || op_b !== 32'h1 || alu_op !== 4'd9)
         begin bad++; $display("FAIL srai got ill=%0b a=%h b=%h op=%0d exp 0/80000000/1/9", illegal, op_a, op_b, alu_op); end
      // ADD x0,x1,x2 is legal but must not write back
      drive(1'b1, 32'h00208033, 32'h0, 32'h1, 32'h2, 1'b1, 1'b0);
      step();
      total++; if (rd_we !== 1'b0 || illegal !== 1'b0 || op_b !== 32'h2)
         begin bad++; $display("FAIL add_x0 got we=%0b ill=%0b b=%h exp 0/0/2", rd_we, illegal, op_b); end
   endtask

   task automatic test_backpressure();
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 32'hFFF00093, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h402081B3, 32'h0, 32'h10, 32'h3, 1'b0, 1'b0);
      #1;
      total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%0b exp=0", instr_ready); end
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (ex_valid !== 1'b1 || op_b !== 32'hFFFFFFFF || alu_op !== 4'd0 || rd_addr !== 5'd1 || issued_count !== 32'd0)
            begin bad++; $display("FAIL bp_hold%0d got v=%0b b=%h op=%0d rd=%0d cnt=%0d exp 1/ffffffff/0/1/0", i, ex_valid, op_b, alu_op, rd_addr, issued_count); end
      end
      @(negedge clk);
      ex_ready = 1'b1;
      #1;
      total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b exp=1", instr_ready); end
      step();
      total++; if (op_a !== 32'h10 || alu_op !== 4'd1 || issued_count !== 32'd1 || ex_valid !== 1'b1)
         begin bad++; $display("FAIL bp_release got a=%h op=%0d cnt=%0d v=%0b exp 10/1/1/1", op_a, alu_op, issued_count, ex_valid); end
   endtask

   task automatic test_flush();
      drive(1'b1, 32'hFFF00093, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
      #1;
      total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0b exp=1", instr_ready); end
      step();
      total++; if (ex_valid !== 1'b0 || issued_count !== 32'd1)
         begin bad++; $display("FAIL flush got v=%0b cnt=%0d exp 0/1", ex_valid, issued_count); end
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      total++; if (ex_valid !== 1'b0 || issued_count !== 32'd1)
         begin bad++; $display("FAIL post_flush got v=%0b cnt=%0d exp 0/1", ex_valid, issued_count); end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      dut.issued_count_q = 32'hFFFFFFFF;
      drive(1'b1, 32'h00100093, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      total++; if (issued_count !== 32'hFFFFFFFF || ex_valid !== 1'b1)
         begin bad++; $display("FAIL wrap_pre got cnt=%h v=%0b exp ffffffff/1", issued_count, ex_valid); end
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      total++; if (issued_count !== 32'h0 || ex_valid !== 1'b0)
         begin bad++; $display("FAIL wrap got cnt=%h v=%0b exp 0/0", issued_count, ex_valid); end
   endtask

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instr = '0; pc = '0;
      rs1_data = '0; rs2_data = '0; flush = 1'b0; ex_ready = 1'b0;
      test_reset();
      test_back_to_back();
      test_lui_jal();
      test_illegal();
      test_backpressure();
      test_flush();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
